// File: rtl/teng_pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: sync headers, block type bytes,
// XGMII control characters, block classes and the RX decoder states.
package teng_pcs_pkg;

  // Sync headers
  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  // Control block type bytes (payload bits [7:0])
  localparam logic [7:0] BT_IDLE   = 8'h1E;
  localparam logic [7:0] BT_START0 = 8'h78;
  localparam logic [7:0] BT_START4 = 8'h33;
  localparam logic [7:0] BT_TERM0  = 8'h87;
  localparam logic [7:0] BT_TERM1  = 8'h99;
  localparam logic [7:0] BT_TERM2  = 8'hAA;
  localparam logic [7:0] BT_TERM3  = 8'hB4;
  localparam logic [7:0] BT_TERM4  = 8'hCC;
  localparam logic [7:0] BT_TERM5  = 8'hD2;
  localparam logic [7:0] BT_TERM6  = 8'hE1;
  localparam logic [7:0] BT_TERM7  = 8'hFF;

  // XGMII characters
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  // Whole-column patterns
  localparam logic [63:0] COL_IDLE  = {8{XGMII_IDLE}};
  localparam logic [63:0] COL_ERROR = {8{XGMII_ERROR}};

  // Marker returned when a type byte is not a terminate type
  localparam logic [3:0] TERM_NONE = 4'hF;

  typedef enum logic [2:0] {
    BLK_C,
    BLK_S,
    BLK_D,
    BLK_T,
    BLK_E
  } blk_class_e;

  typedef enum logic [1:0] {
    RX_INIT,
    RX_C,
    RX_D,
    RX_E
  } rx_state_e;

  // Number of data bytes carried by a terminate block, TERM_NONE otherwise
  function automatic logic [3:0] term_data_bytes(input logic [7:0] type_byte);
    logic [3:0] n;
    case (type_byte)
      BT_TERM0: n = 4'd0;
      BT_TERM1: n = 4'd1;
      BT_TERM2: n = 4'd2;
      BT_TERM3: n = 4'd3;
      BT_TERM4: n = 4'd4;
      BT_TERM5: n = 4'd5;
      BT_TERM6: n = 4'd6;
      BT_TERM7: n = 4'd7;
      default:  n = TERM_NONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rx_block_classify.sv
// Combinational 66b block classifier: maps sync header and type byte to a
// block class and builds the XGMII column the block decodes to when it is
// accepted by the receive state machine.
module rx_block_classify
  import teng_pcs_pkg::*;
(
  input  logic [1:0]  head_i,
  input  logic [63:0] data_i,
  output blk_class_e  blk_class_o,
  output logic [63:0] col_rxd_o,
  output logic [7:0]  col_rxc_o
);

  logic [7:0]  type_byte;
  logic [3:0]  term_n;
  logic [63:0] term_rxd;

  assign type_byte = data_i[7:0];
  assign term_n    = term_data_bytes(type_byte);

  // Classify the block from its header and, for control blocks, its type byte
  always_comb begin
    blk_class_o = BLK_E;
    if (head_i == SH_DATA) begin
      blk_class_o = BLK_D;
    end else if (head_i == SH_CTRL) begin
      if (type_byte == BT_IDLE) begin
        blk_class_o = BLK_C;
      end else if ((type_byte == BT_START0) || (type_byte == BT_START4)) begin
        blk_class_o = BLK_S;
      end else if (term_n != TERM_NONE) begin
        blk_class_o = BLK_T;
      end
    end
  end

  // Terminate column, one lane at a time: lanes below n carry payload byte
  // (lane+1), lane n carries the terminate character, higher lanes idle.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_term_lane
      if (gi < 7) begin : g_with_data
        assign term_rxd[gi*8 +: 8] = (term_n > 4'(gi))  ? data_i[(gi+1)*8 +: 8] :
                                     (term_n == 4'(gi)) ? XGMII_TERM : XGMII_IDLE;
      end else begin : g_last
        assign term_rxd[gi*8 +: 8] = (term_n == 4'(gi)) ? XGMII_TERM : XGMII_IDLE;
      end
    end
  endgenerate

  // Select the decoded column for the block class; unknown blocks give an error column
  always_comb begin
    col_rxd_o = COL_ERROR;
    col_rxc_o = 8'hFF;
    case (blk_class_o)
      BLK_D: begin
        col_rxd_o = data_i;
        col_rxc_o = 8'h00;
      end
      BLK_C: begin
        col_rxd_o = COL_IDLE;
        col_rxc_o = 8'hFF;
      end
      BLK_S: begin
        if (type_byte == BT_START0) begin
          col_rxd_o = {data_i[63:8], XGMII_START};
          col_rxc_o = 8'h01;
        end else begin
          col_rxd_o = {data_i[63:40], XGMII_START, XGMII_IDLE, XGMII_IDLE,
                       XGMII_IDLE, XGMII_IDLE};
          col_rxc_o = 8'h1F;
        end
      end
      BLK_T: begin
        col_rxd_o = term_rxd;
        col_rxc_o = 8'hFF << term_n;
      end
      default: begin
        col_rxd_o = COL_ERROR;
        col_rxc_o = 8'hFF;
      end
    endcase
  end

endmodule

// File: rtl/decode_66b_64b.sv
// 64b/66b receive decoder: one 66-bit block in, one XGMII column out, one
// cycle later. A receive state machine checks frame sequencing and replaces
// any out-of-sequence or malformed block with an error column.
// Optional macro DECODE_ERR_CNT_EN adds the saturating error counter and its
// clear input; without it err_cnt_o is held at zero.
module decode_66b_64b
  import teng_pcs_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [63:0]          decode_data_i,
  input  logic [1:0]           decode_head_i,
  input  logic                 decode_data_vld_i,
  input  logic                 err_cnt_clr_i,
  output logic [63:0]          xgmii_rxd_o,
  output logic [7:0]           xgmii_rxc_o,
  output logic                 xgmii_rxd_vld_o,
  output logic                 decode_error_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  blk_class_e  blk_class;
  logic [63:0] col_rxd;
  logic [7:0]  col_rxc;

  rx_state_e   state_q, state_d;
  logic        violation;

  logic [63:0] rxd_q, rxd_d;
  logic [7:0]  rxc_q, rxc_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  rx_block_classify u_classify (
    .head_i      (decode_head_i),
    .data_i      (decode_data_i),
    .blk_class_o (blk_class),
    .col_rxd_o   (col_rxd),
    .col_rxc_o   (col_rxc)
  );

  // Next receive state and sequencing-violation flag for each valid block
  always_comb begin
    state_d   = state_q;
    violation = 1'b0;
    if (decode_data_vld_i) begin
      case (state_q)
        RX_INIT, RX_C: begin
          if (blk_class == BLK_C) begin
            state_d = RX_C;
          end else if (blk_class == BLK_S) begin
            state_d = RX_D;
          end else begin
            violation = 1'b1;
          end
        end
        RX_D: begin
          if (blk_class == BLK_D) begin
            state_d = RX_D;
          end else if (blk_class == BLK_T) begin
            state_d = RX_C;
          end else begin
            violation = 1'b1;
          end
        end
        RX_E: begin
          // Any well-formed block re-synchronises the decoder
          if ((blk_class == BLK_C) || (blk_class == BLK_T)) begin
            state_d = RX_C;
          end else if ((blk_class == BLK_S) || (blk_class == BLK_D)) begin
            state_d = RX_D;
          end else begin
            violation = 1'b1;
          end
        end
        default: begin
          violation = 1'b1;
        end
      endcase
      if (violation) begin
        state_d = RX_E;
      end
    end
  end

  // Next output column: decoded block, error column on violation, hold when idle
  always_comb begin
    rxd_d = rxd_q;
    rxc_d = rxc_q;
    vld_d = decode_data_vld_i;
    err_d = 1'b0;
    if (decode_data_vld_i) begin
      if (violation) begin
        rxd_d = COL_ERROR;
        rxc_d = 8'hFF;
        err_d = 1'b1;
      end else begin
        rxd_d = col_rxd;
        rxc_d = col_rxc;
      end
    end
  end

  // Receive state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RX_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Output column registers; reset presents an idle column
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rxd_q <= COL_IDLE;
      rxc_q <= 8'hFF;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rxd_q <= rxd_d;
      rxc_q <= rxc_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign xgmii_rxd_o     = rxd_q;
  assign xgmii_rxc_o     = rxc_q;
  assign xgmii_rxd_vld_o = vld_q;
  assign decode_error_o  = err_q;

`ifdef DECODE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error-column count; clear wins over a same-cycle increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Error counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_cnt_clr;

  assign unused_err_cnt_clr = err_cnt_clr_i;
  assign err_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_decode_66b_64b.sv
// Self-checking bench for decode_66b_64b. Expected columns are pushed to a
// scoreboard when each block is driven and popped when the column appears.
module tb_decode_66b_64b;

  localparam int CW = 4;
  localparam logic [63:0] IDLE_COL = 64'h0707070707070707;
  localparam logic [63:0] ERR_COL  = 64'hFEFEFEFEFEFEFEFE;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [63:0]   decode_data_i;
  logic [1:0]    decode_head_i;
  logic          decode_data_vld_i;
  logic          err_cnt_clr_i;
  logic [63:0]   xgmii_rxd_o;
  logic [7:0]    xgmii_rxc_o;
  logic          xgmii_rxd_vld_o;
  logic          decode_error_o;
  logic [CW-1:0] err_cnt_o;

  always #5 clk_i = ~clk_i;

  decode_66b_64b #(.ERR_CNT_W(CW)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .decode_data_i     (decode_data_i),
    .decode_head_i     (decode_head_i),
    .decode_data_vld_i (decode_data_vld_i),
    .err_cnt_clr_i     (err_cnt_clr_i),
    .xgmii_rxd_o       (xgmii_rxd_o),
    .xgmii_rxc_o       (xgmii_rxc_o),
    .xgmii_rxd_vld_o   (xgmii_rxd_vld_o),
    .decode_error_o    (decode_error_o),
    .err_cnt_o         (err_cnt_o)
  );

  typedef struct packed {
    logic [63:0]   rxd;
    logic [7:0]    rxc;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  string         tag_q[$];
  logic [CW-1:0] model_cnt = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Push the expected column and advance the counter model
  task automatic push(input logic [63:0] rxd, input logic [7:0] rxc, input logic err,
                      input logic clr, input string tag);
    exp_t e;
`ifdef DECODE_ERR_CNT_EN
    if (clr) model_cnt = '0;
    else if (err && (model_cnt != {CW{1'b1}})) model_cnt = model_cnt + CW'(1);
`endif
    e.rxd = rxd;
    e.rxc = rxc;
    e.err = err;
    e.cnt = model_cnt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic send(input logic [1:0] h, input logic [63:0] d, input logic clr,
                      input logic [63:0] rxd, input logic [7:0] rxc, input logic err,
                      input string tag);
    @(posedge clk_i);
    #1;
    decode_head_i     = h;
    decode_data_i     = d;
    decode_data_vld_i = 1'b1;
    err_cnt_clr_i     = clr;
    push(rxd, rxc, err, clr, tag);
  endtask

  task automatic send_err(input logic [1:0] h, input logic [63:0] d, input logic clr,
                          input string tag);
    send(h, d, clr, ERR_COL, 8'hFF, 1'b1, tag);
  endtask

  task automatic gap();
    @(posedge clk_i);
    #1;
    decode_data_vld_i = 1'b0;
    err_cnt_clr_i     = 1'b0;
  endtask

  // Scoreboard monitor: compare every valid column against the queue head
  always @(negedge clk_i) begin
    if (xgmii_rxd_vld_o) begin
      check("sb_not_empty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        $display("col %-14s rxd=%h rxc=%h err=%b cnt=%0d", t, xgmii_rxd_o, xgmii_rxc_o,
                 decode_error_o, err_cnt_o);
        check({t, ".rxd"}, xgmii_rxd_o, e.rxd);
        check({t, ".rxc"}, 64'(xgmii_rxc_o), 64'(e.rxc));
        check({t, ".err"}, 64'(decode_error_o), 64'(e.err));
        check({t, ".cnt"}, 64'(err_cnt_o), 64'(e.cnt));
      end
    end else if (rst_n_i === 1'b1) begin
      check("err_low_when_idle", 64'(decode_error_o), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_i           = 1'b0;
    decode_data_i     = '0;
    decode_head_i     = 2'b00;
    decode_data_vld_i = 1'b0;
    err_cnt_clr_i     = 1'b0;
    #12;
    check("rst.rxd", xgmii_rxd_o, IDLE_COL);
    check("rst.rxc", 64'(xgmii_rxc_o), 64'hFF);
    check("rst.vld", 64'(xgmii_rxd_vld_o), 64'd0);
    check("rst.err", 64'(decode_error_o), 64'd0);
    check("rst.cnt", 64'(err_cnt_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Idle and a complete frame
    send(2'b01, 64'h000000000000001E, 1'b0, IDLE_COL, 8'hFF, 1'b0, "idle");
    send(2'b01, 64'h5555555555555578, 1'b0, 64'h55555555555555FB, 8'h01, 1'b0, "start0");
    send(2'b10, 64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF, 8'h00, 1'b0, "data_a");
    send(2'b10, 64'hFEDCBA9876543210, 1'b0, 64'hFEDCBA9876543210, 8'h00, 1'b0, "data_b");
    send(2'b01, 64'hAABBCCDD332211B4, 1'b0, 64'h07070707FD332211, 8'hF8, 1'b0, "term3");

    // Bad header mid-frame, then recovery on idle
    send(2'b01, 64'h5555555555555578, 1'b0, 64'h55555555555555FB, 8'h01, 1'b0, "start0_b");
    send_err(2'b11, 64'h0123456789ABCDEF, 1'b0, "hdr11");
    send(2'b01, 64'h000000000000001E, 1'b0, IDLE_COL, 8'hFF, 1'b0, "idle_recover");

    // Data directly after idle, recovery on a lane-4 start
    send_err(2'b10, 64'h1111111111111111, 1'b0, "data_in_c");
    send(2'b01, 64'h9988770000000033, 1'b0, 64'h998877FB07070707, 8'h1F, 1'b0, "start4");
    send(2'b01, 64'hDEADBEEF00000087, 1'b0, 64'h07070707070707FD, 8'hFF, 1'b0, "term0");

    // Terminate boundary lengths
    send(2'b01, 64'h0102030405060778, 1'b0, 64'h01020304050607FB, 8'h01, 1'b0, "start0_c");
    send(2'b01, 64'h77665544332211FF, 1'b0, 64'hFD77665544332211, 8'h80, 1'b0, "term7");
    send(2'b01, 64'hA1A2A3A4A5A6A778, 1'b0, 64'hA1A2A3A4A5A6A7FB, 8'h01, 1'b0, "start0_d");
    send(2'b01, 64'h99999999992211AA, 1'b0, 64'h0707070707FD2211, 8'hFC, 1'b0, "term2");

    // Other sequencing violations and a bad type byte
    send_err(2'b01, 64'h0000000000000087, 1'b0, "term_in_c");
    send(2'b01, 64'h000000000000001E, 1'b0, IDLE_COL, 8'hFF, 1'b0, "idle_c");
    send(2'b01, 64'h1212121212121278, 1'b0, 64'h12121212121212FB, 8'h01, 1'b0, "start0_e");
    send_err(2'b01, 64'h3434343434343478, 1'b0, "start_in_d");
    send(2'b10, 64'h0F0F0F0F0F0F0F0F, 1'b0, 64'h0F0F0F0F0F0F0F0F, 8'h00, 1'b0, "data_recover");
    send(2'b01, 64'h123456789ABC1199, 1'b0, 64'h070707070707FD11, 8'hFE, 1'b0, "term1");
    send_err(2'b01, 64'h0000000000000055, 1'b0, "bad_type");
    send(2'b01, 64'h000000000000001E, 1'b0, IDLE_COL, 8'hFF, 1'b0, "idle_d");

    // Valid held low mid-frame: outputs hold, frame continues cleanly
    send(2'b01, 64'h5555555555555578, 1'b0, 64'h55555555555555FB, 8'h01, 1'b0, "start0_f");
    send(2'b10, 64'hC0FFEE0012345678, 1'b0, 64'hC0FFEE0012345678, 8'h00, 1'b0, "data_pre_gap");
    gap();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      check("gap.vld", 64'(xgmii_rxd_vld_o), 64'd0);
      check("gap.rxd", xgmii_rxd_o, 64'hC0FFEE0012345678);
      check("gap.rxc", 64'(xgmii_rxc_o), 64'h00);
    end
    send(2'b10, 64'h8877665544332211, 1'b0, 64'h8877665544332211, 8'h00, 1'b0, "data_post_gap");
    send(2'b01, 64'h0000000000000087, 1'b0, 64'h07070707070707FD, 8'hFF, 1'b0, "term0_b");

    // Drive the counter into saturation, then clear against a same-cycle error
    for (int i = 0; i < 16; i++) begin
      send_err(2'b00, 64'(i), 1'b0, "hdr00_sat");
    end
    send_err(2'b11, 64'h0000000000000000, 1'b1, "clr_with_err");
    send(2'b01, 64'h000000000000001E, 1'b0, IDLE_COL, 8'hFF, 1'b0, "idle_e");

    // Asynchronous reset in the middle of a frame
    send_err(2'b11, 64'h0000000000000000, 1'b0, "pre_rst_err");
    send(2'b01, 64'h6666666666666678, 1'b0, 64'h66666666666666FB, 8'h01, 1'b0, "start0_g");
    send(2'b10, 64'h0A0B0C0D0E0F1011, 1'b0, 64'h0A0B0C0D0E0F1011, 8'h00, 1'b0, "data_pre_rst");
    gap();
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_n_i   = 1'b0;
    model_cnt = '0;
    #1;
    check("mid_rst.rxd", xgmii_rxd_o, IDLE_COL);
    check("mid_rst.rxc", 64'(xgmii_rxc_o), 64'hFF);
    check("mid_rst.vld", 64'(xgmii_rxd_vld_o), 64'd0);
    check("mid_rst.cnt", 64'(err_cnt_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    send_err(2'b10, 64'h2222222222222222, 1'b0, "data_after_rst");
    send(2'b01, 64'h7777777777777778, 1'b0, 64'h77777777777777FB, 8'h01, 1'b0, "start_after_rst");
    gap();

    repeat (4) @(negedge clk_i);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
